// File: rtl/ss_fifo_sync_fwft_if.sv
// Handshake and status bundle between a producer/consumer pair and ss_fifo_sync_fwft.
// The master side drives write/pop/clear requests; the slave (FIFO) side drives data and status.
interface ss_fifo_sync_fwft_if #(
  parameter int Bw_d = 8,
  parameter int Bw_a = 10
);
  logic [Bw_d-1:0] wr_di;
  logic            wr_en;
  logic            rd_en;
  logic            err_clr;
  logic            wr_rdy;
  logic            rd_rdy;
  logic [Bw_d-1:0] rd_do;
  logic            rd_vld;
  logic            full;
  logic            empty;
  logic [Bw_a:0]   count;
  logic            ovf;
  logic            udf;

  modport master (
    output wr_di, wr_en, rd_en, err_clr,
    input  wr_rdy, rd_rdy, rd_do, rd_vld, full, empty, count, ovf, udf
  );

  modport slave (
    input  wr_di, wr_en, rd_en, err_clr,
    output wr_rdy, rd_rdy, rd_do, rd_vld, full, empty, count, ovf, udf
  );
endinterface

// File: rtl/ss_fifo_sync_fwft.sv
// Single-clock FIFO with selectable show-ahead or registered read, occupancy count,
// threshold flags and sticky overflow/underflow errors.
module ss_fifo_sync_fwft #(
  parameter int Bw_d    = 8,
  parameter int Bw_a    = 10,
  parameter int Thrs_wr = (1 << Bw_a) / 4 * 3,
  parameter int Thrs_rd = 1,
  parameter bit Fwft    = 1'b1
) (
  input logic               clk,
  input logic               reset,
  ss_fifo_sync_fwft_if.slave s_bus
);

  localparam int            Depth       = 1 << Bw_a;
  localparam logic [Bw_a:0] LP_DEPTH    = (Bw_a + 1)'(Depth);
  localparam logic [Bw_a:0] LP_THRS_WR  = (Bw_a + 1)'(Thrs_wr);
  localparam logic [Bw_a:0] LP_THRS_RD  = (Bw_a + 1)'(Thrs_rd);
  localparam logic [Bw_a:0] LP_ONE      = {{Bw_a{1'b0}}, 1'b1};

  logic [Bw_d-1:0] r_mem [Depth];
  logic [Bw_a:0]   r_wr_ptr;
  logic [Bw_a:0]   r_rd_ptr;
  logic [Bw_a:0]   r_count;
  logic [Bw_d-1:0] r_do;
  logic            r_vld;
  logic            r_ovf;
  logic            r_udf;

  logic            w_full;
  logic            w_empty;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_wr_rej;
  logic            w_rd_rej;
  logic            w_mem_nempty;
  logic            w_load;
  logic            w_load_mem;
  logic            w_bypass;
  logic            w_mem_wr;
  logic            w_vld_nxt;
  logic [Bw_d-1:0] w_mem_head;

  assign w_full       = (r_count == LP_DEPTH);
  assign w_empty      = (r_count == '0);
  assign w_wr_acc     = s_bus.wr_en & ~w_full;
  assign w_rd_acc     = s_bus.rd_en & ~w_empty;
  assign w_wr_rej     = s_bus.wr_en & w_full;
  assign w_rd_rej     = s_bus.rd_en & w_empty;
  assign w_mem_nempty = (r_wr_ptr != r_rd_ptr);
  assign w_mem_head   = r_mem[r_rd_ptr[Bw_a-1:0]];
  assign w_mem_wr     = w_wr_acc & ~w_bypass;

  // In show-ahead mode the output register is part of the storage: it refills from
  // memory whenever it frees up, or straight from wr_di when memory has nothing queued,
  // so a write into an empty FIFO is visible one edge later and pops never bubble.
  always_comb begin
    w_load     = 1'b0;
    w_load_mem = 1'b0;
    w_bypass   = 1'b0;
    w_vld_nxt  = r_vld;
    if (Fwft) begin
      w_load     = ~r_vld | w_rd_acc;
      w_load_mem = w_load & w_mem_nempty;
      w_bypass   = w_load & ~w_mem_nempty & w_wr_acc;
      if (w_load) begin
        w_vld_nxt = w_load_mem | w_bypass;
      end
    end else begin
      w_load_mem = w_rd_acc;
      w_vld_nxt  = w_rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr[Bw_a-1:0]] <= s_bus.wr_di;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_do     <= '0;
      r_vld    <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + LP_ONE;
      end
      if (w_load_mem) begin
        r_rd_ptr <= r_rd_ptr + LP_ONE;
        r_do     <= w_mem_head;
      end else if (w_bypass) begin
        r_do <= s_bus.wr_di;
      end
      r_vld <= w_vld_nxt;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
      // A new error in the same cycle as err_clr wins.
      r_ovf <= (r_ovf & ~s_bus.err_clr) | w_wr_rej;
      r_udf <= (r_udf & ~s_bus.err_clr) | w_rd_rej;
    end
  end

  assign s_bus.full   = w_full;
  assign s_bus.empty  = w_empty;
  assign s_bus.count  = r_count;
  assign s_bus.wr_rdy = (r_count <= LP_THRS_WR);
  assign s_bus.rd_rdy = (r_count >= LP_THRS_RD);
  assign s_bus.rd_do  = r_do;
  assign s_bus.rd_vld = r_vld;
  assign s_bus.ovf    = r_ovf;
  assign s_bus.udf    = r_udf;

endmodule

// File: tb/tb_ss_fifo_sync_fwft.sv
// Directed bench for ss_fifo_sync_fwft: show-ahead, registered-read and threshold variants
// at depth 8, each with hand-computed expectations.
module tb_ss_fifo_sync_fwft;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  ss_fifo_sync_fwft_if #(.Bw_d(8), .Bw_a(3)) if_a ();
  ss_fifo_sync_fwft_if #(.Bw_d(8), .Bw_a(3)) if_b ();
  ss_fifo_sync_fwft_if #(.Bw_d(8), .Bw_a(3)) if_c ();

  ss_fifo_sync_fwft #(.Bw_d(8), .Bw_a(3), .Fwft(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .s_bus(if_a.slave));
  ss_fifo_sync_fwft #(.Bw_d(8), .Bw_a(3), .Fwft(1'b0)) u_std (
    .clk(clk), .reset(reset), .s_bus(if_b.slave));
  ss_fifo_sync_fwft #(.Bw_d(8), .Bw_a(3), .Thrs_rd(3), .Fwft(1'b1)) u_thr (
    .clk(clk), .reset(reset), .s_bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic we, input logic [7:0] di, input logic re, input logic ec);
    if_a.wr_en = we; if_a.wr_di = di; if_a.rd_en = re; if_a.err_clr = ec;
  endtask

  task automatic drv_b(input logic we, input logic [7:0] di, input logic re);
    if_b.wr_en = we; if_b.wr_di = di; if_b.rd_en = re; if_b.err_clr = 1'b0;
  endtask

  task automatic drv_c(input logic we, input logic [7:0] di, input logic re);
    if_c.wr_en = we; if_c.wr_di = di; if_c.rd_en = re; if_c.err_clr = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drv_a(1'b0, 8'h00, 1'b0, 1'b0);
    drv_b(1'b0, 8'h00, 1'b0);
    drv_c(1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset values
    chk("rst_count",  32'(if_a.count),  32'd0);
    chk("rst_empty",  32'(if_a.empty),  32'd1);
    chk("rst_full",   32'(if_a.full),   32'd0);
    chk("rst_wr_rdy", 32'(if_a.wr_rdy), 32'd1);
    chk("rst_rd_rdy", 32'(if_a.rd_rdy), 32'd0);
    chk("rst_rd_vld", 32'(if_a.rd_vld), 32'd0);
    chk("rst_rd_do",  32'(if_a.rd_do),  32'h00);
    chk("rst_ovf",    32'(if_a.ovf),    32'd0);
    chk("rst_udf",    32'(if_a.udf),    32'd0);
    chk("rst_b_vld",  32'(if_b.rd_vld), 32'd0);
    chk("rst_c_rdy",  32'(if_c.rd_rdy), 32'd0);

    // reset in the middle of a 5-word burst
    drv_a(1'b1, 8'h51, 1'b0, 1'b0); tick();
    drv_a(1'b1, 8'h52, 1'b0, 1'b0); tick();
    drv_a(1'b1, 8'h53, 1'b0, 1'b0); reset = 1'b1; tick();
    reset = 1'b0;
    chk("midrst_count", 32'(if_a.count),  32'd0);
    chk("midrst_empty", 32'(if_a.empty),  32'd1);
    chk("midrst_vld",   32'(if_a.rd_vld), 32'd0);
    drv_a(1'b1, 8'h54, 1'b0, 1'b0); tick();
    drv_a(1'b1, 8'h55, 1'b0, 1'b0); tick();
    chk("midrst_after_count", 32'(if_a.count), 32'd2);
    chk("midrst_after_head",  32'(if_a.rd_do), 32'h54);
    drv_a(1'b0, 8'h00, 1'b0, 1'b0); reset = 1'b1; tick();
    reset = 1'b0; tick();
    chk("clean_count", 32'(if_a.count), 32'd0);

    // fill 0x01..0x08
    for (int k = 1; k <= 8; k++) begin
      drv_a(1'b1, 8'(k), 1'b0, 1'b0);
      tick();
      if (k == 1) begin
        chk("wr_empty_vld",   32'(if_a.rd_vld), 32'd1);
        chk("wr_empty_do",    32'(if_a.rd_do),  32'h01);
        chk("wr_empty_empty", 32'(if_a.empty),  32'd0);
      end
      chk("fill_count",  32'(if_a.count),  32'(k));
      chk("fill_wr_rdy", 32'(if_a.wr_rdy), (k <= 6) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(if_a.full), 32'd1);

    // overflow write of 0xAA
    drv_a(1'b1, 8'hAA, 1'b0, 1'b0); tick();
    chk("ovf_flag",  32'(if_a.ovf),   32'd1);
    chk("ovf_count", 32'(if_a.count), 32'd8);

    // drain back-to-back
    for (int k = 1; k <= 8; k++) begin
      chk("drain_vld", 32'(if_a.rd_vld), 32'd1);
      chk("drain_do",  32'(if_a.rd_do),  32'(k));
      drv_a(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
    end
    drv_a(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drain_empty", 32'(if_a.empty),  32'd1);
    chk("drain_vld0",  32'(if_a.rd_vld), 32'd0);
    chk("drain_hold",  32'(if_a.rd_do),  32'h08);

    // underflow
    drv_a(1'b0, 8'h00, 1'b1, 1'b0); tick();
    chk("udf_flag",  32'(if_a.udf),   32'd1);
    chk("udf_count", 32'(if_a.count), 32'd0);
    chk("udf_hold",  32'(if_a.rd_do), 32'h08);
    drv_a(1'b0, 8'h00, 1'b0, 1'b1); tick();
    chk("clr_ovf", 32'(if_a.ovf), 32'd0);
    chk("clr_udf", 32'(if_a.udf), 32'd0);

    // write+pop while empty: write wins, udf set
    drv_a(1'b1, 8'h3C, 1'b1, 1'b0); tick();
    chk("rw_empty_count", 32'(if_a.count),  32'd1);
    chk("rw_empty_udf",   32'(if_a.udf),    32'd1);
    chk("rw_empty_do",    32'(if_a.rd_do),  32'h3C);
    chk("rw_empty_vld",   32'(if_a.rd_vld), 32'd1);
    drv_a(1'b0, 8'h00, 1'b1, 1'b0); tick();
    // clear coinciding with a fresh underflow keeps the flag
    drv_a(1'b0, 8'h00, 1'b1, 1'b1); tick();
    chk("clr_vs_err_udf", 32'(if_a.udf), 32'd1);
    drv_a(1'b0, 8'h00, 1'b0, 1'b1); tick();
    chk("clr_udf2", 32'(if_a.udf), 32'd0);

    // write+pop while full: pop wins, ovf set
    for (int k = 0; k < 8; k++) begin
      drv_a(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
      tick();
    end
    drv_a(1'b1, 8'hBB, 1'b1, 1'b0); tick();
    chk("rw_full_count", 32'(if_a.count), 32'd7);
    chk("rw_full_ovf",   32'(if_a.ovf),   32'd1);
    for (int k = 1; k < 8; k++) begin
      chk("rw_full_drain", 32'(if_a.rd_do), 32'(8'h10 + k));
      drv_a(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
    end
    drv_a(1'b0, 8'h00, 1'b0, 1'b1); tick();
    chk("rw_full_empty", 32'(if_a.empty), 32'd1);

    // wrap stress at count 4
    for (int k = 0; k < 4; k++) begin
      drv_a(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      chk("wrap_do", 32'(if_a.rd_do), 32'(8'h20 + k));
      drv_a(1'b1, 8'(8'h24 + k), 1'b1, 1'b0);
      tick();
      chk("wrap_count", 32'(if_a.count), 32'd4);
    end
    drv_a(1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_tail", 32'(if_a.rd_do), 32'h48);

    // registered-read mode
    drv_b(1'b1, 8'h11, 1'b0); tick();
    drv_b(1'b1, 8'h22, 1'b0); tick();
    drv_b(1'b0, 8'h00, 1'b0);
    chk("std_count", 32'(if_b.count),  32'd2);
    chk("std_vld0",  32'(if_b.rd_vld), 32'd0);
    chk("std_do0",   32'(if_b.rd_do),  32'h00);
    drv_b(1'b0, 8'h00, 1'b1); tick();
    chk("std_do1",  32'(if_b.rd_do),  32'h11);
    chk("std_vld1", 32'(if_b.rd_vld), 32'd1);
    drv_b(1'b0, 8'h00, 1'b1); tick();
    chk("std_do2",  32'(if_b.rd_do),  32'h22);
    chk("std_vld2", 32'(if_b.rd_vld), 32'd1);
    drv_b(1'b0, 8'h00, 1'b0); tick();
    chk("std_vld3",  32'(if_b.rd_vld), 32'd0);
    chk("std_hold",  32'(if_b.rd_do),  32'h22);
    chk("std_empty", 32'(if_b.empty),  32'd1);
    drv_b(1'b0, 8'h00, 1'b1); tick();
    drv_b(1'b0, 8'h00, 1'b0);
    chk("std_udf",   32'(if_b.udf),   32'd1);
    chk("std_hold2", 32'(if_b.rd_do), 32'h22);

    // read threshold of 3
    for (int k = 1; k <= 3; k++) begin
      drv_c(1'b1, 8'(8'h60 + k), 1'b0);
      tick();
      chk("thr_rd_rdy", 32'(if_c.rd_rdy), (k >= 3) ? 32'd1 : 32'd0);
    end
    drv_c(1'b0, 8'h00, 1'b1); tick();
    drv_c(1'b0, 8'h00, 1'b0);
    chk("thr_count",  32'(if_c.count),  32'd2);
    chk("thr_rd_rdy_fall", 32'(if_c.rd_rdy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
